f_ifu: RTL and testbench

Fetch stage of the 5-stage MIPS pipeline. Holds the F-stage PC and fetches instructions from an instruction memory with a variable-latency valid handshake. Drives the F/D pipeline register (D_pc, D_instr, D_valid), honours the hazard-unit stall, and takes the next PC from the D-stage NPC logic. It preserves a D-stage redirect that would otherwise be lost while a slow fetch is outstanding.

---
 rtl/f_ifu_pkg.sv | 15 +
 rtl/f_fd_reg.sv | 35 +++
 rtl/f_ifu.sv | 122 ++++++++++++
 tb/tb_f_ifu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/f_ifu_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package f_ifu_pkg;

    // Fetch handshake states: issuing a request, waiting for a slow response,
    // or holding a completed word while the pipeline is frozen.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/f_fd_reg.sv
// F/D pipeline register: load a fetched instruction, insert a bubble, or hold.
module f_fd_reg
    import f_ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid
);

    // Load wins over bubble; a bubble keeps the PC so D_pc still names the
    // last instruction that passed through.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            d_pc    <= 32'h0;
            d_instr <= NOP;
            d_valid <= 1'b0;
        end else if (load) begin
            d_pc    <= pc_in;
            d_instr <= instr_in;
            d_valid <= 1'b1;
        end else if (bubble) begin
            d_instr <= NOP;
            d_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/f_ifu.sv
// Fetch stage: F-stage PC, single-outstanding instruction-memory handshake,
// stall buffer and capture of a D-stage redirect during slow fetches.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned next-PC detection).
module f_ifu
    import f_ifu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_rvalid,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        exc_adel
);

    fetch_state_t state;
    logic [31:0]  buf_q;
    logic [31:0]  npc_q;
    logic         pend;

    logic         fetch_done;
    logic         advance;
    logic         bubble;
    logic [31:0]  word;
    logic [31:0]  next_pc;
    logic [31:0]  fd_instr;

    // A response only counts while a request is outstanding; in HOLD the
    // buffered word is the completion and the bus is ignored.
    assign fetch_done = (state != HOLD) && im_rvalid;
    assign advance    = !stall && (fetch_done || (state == HOLD));
    assign bubble     = !stall && !advance;
    assign word       = (state == HOLD) ? buf_q : im_rdata;
    assign next_pc    = pend ? npc_q : npc;

    assign im_req  = (state == REQ);
    assign im_addr = F_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel_q;

    // Sticky flag: once a misaligned PC is selected, later fetches are
    // replaced by nops so nothing from the bad address executes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            adel_q <= 1'b0;
        else if (advance && (next_pc[1:0] != 2'b00))
            adel_q <= 1'b1;
    end

    assign exc_adel = adel_q;
    assign fd_instr = adel_q ? NOP : word;
`else
    assign exc_adel = 1'b0;
    assign fd_instr = word;
`endif

    // Handshake FSM, PC update, stall buffer and redirect capture.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the buffer is a single register, so it is reset along with
        // the rest of the state and never exposes an unknown word.
        if (reset) begin
            state <= REQ;
            F_pc  <= PC_RESET;
            npc_q <= 32'h0;
            pend  <= 1'b0;
            buf_q <= 32'h0;
        end else begin
            if (advance) begin
                F_pc <= next_pc;
                pend <= 1'b0;
            end else if (bubble && D_valid) begin
                // The D instruction is about to be replaced by a bubble, and
                // its redirect would vanish with it.
                npc_q <= npc;
                pend  <= 1'b1;
            end

            if (fetch_done && stall)
                buf_q <= im_rdata;

            case (state)
                REQ: begin
                    if (fetch_done)
                        state <= stall ? HOLD : REQ;
                    else
                        state <= WAIT;
                end
                WAIT: begin
                    if (fetch_done)
                        state <= stall ? HOLD : REQ;
                end
                HOLD: begin
                    if (!stall)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    f_fd_reg u_fd_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (advance),
        .bubble   (bubble),
        .pc_in    (F_pc),
        .instr_in (fd_instr),
        .d_pc     (D_pc),
        .d_instr  (D_instr),
        .d_valid  (D_valid)
    );

endmodule

// File: tb/tb_f_ifu.sv
// Directed self-checking bench for the fetch stage.
module tb_f_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] npc;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_rvalid;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        exc_adel;

    // Stimulus knobs: sequential npc (F_pc+4) or a forced value; the memory
    // returns a recognisable word per address, optionally corrupted.
    logic        npc_seq;
    logic [31:0] npc_val;
    logic [31:0] corrupt;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    assign npc      = npc_seq ? (im_addr + 32'd4) : npc_val;
    assign im_rdata = mem_word(im_addr) ^ corrupt;

    always #5 clk = ~clk;

    f_ifu dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc       (npc),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .im_rvalid (im_rvalid),
        .F_pc      (f_pc),
        .D_pc      (d_pc),
        .D_instr   (d_instr),
        .D_valid   (d_valid),
        .exc_adel  (exc_adel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one edge and release it just after the edge.
    task automatic do_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        im_rvalid = 1'b0;
        npc_seq   = 1'b1;
        npc_val   = 32'h0;
        corrupt   = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        im_rvalid = 1'b0;
        npc_seq   = 1'b1;
        npc_val   = 32'h0;
        corrupt   = 32'h0;
        #2;

        // Reset state.
        check("rst_f_pc",    f_pc,     32'h0000_3000);
        check("rst_d_pc",    d_pc,     32'h0);
        check("rst_d_instr", d_instr,  32'h0);
        check("rst_d_valid", {31'b0, d_valid},  32'h0);
        check("rst_im_req",  {31'b0, im_req},   32'h1);
        check("rst_adel",    {31'b0, exc_adel}, 32'h0);

        // Zero-wait memory, no stall: one instruction per cycle.
        do_reset();
        im_rvalid = 1'b1;
        tick();
        check("zw_d_pc0",    d_pc,    32'h0000_3000);
        check("zw_d_instr0", d_instr, 32'hA000_3000);
        check("zw_d_valid0", {31'b0, d_valid}, 32'h1);
        check("zw_req0",     {31'b0, im_req},  32'h1);
        tick();
        check("zw_d_pc1",    d_pc,    32'h0000_3004);
        check("zw_req1",     {31'b0, im_req},  32'h1);
        tick();
        check("zw_d_pc2",    d_pc,    32'h0000_3008);
        check("zw_f_pc2",    f_pc,    32'h0000_300C);

        // Two-cycle latency: D_valid 0,0,1 per instruction, address held.
        do_reset();
        tick();
        check("lat_req_w1",   {31'b0, im_req},  32'h0);
        check("lat_addr_w1",  im_addr, 32'h0000_3000);
        check("lat_valid_w1", {31'b0, d_valid}, 32'h0);
        tick();
        check("lat_addr_w2",  im_addr, 32'h0000_3000);
        check("lat_valid_w2", {31'b0, d_valid}, 32'h0);
        im_rvalid = 1'b1;
        tick();
        im_rvalid = 1'b0;
        check("lat_valid_1",  {31'b0, d_valid}, 32'h1);
        check("lat_d_pc_1",   d_pc,    32'h0000_3000);
        check("lat_f_pc_1",   f_pc,    32'h0000_3004);
        tick();
        check("lat_bub_valid", {31'b0, d_valid}, 32'h0);
        check("lat_bub_instr", d_instr, 32'h0);
        check("lat_bub_pc",    d_pc,    32'h0000_3000);
        tick();
        check("lat_bub2_valid", {31'b0, d_valid}, 32'h0);
        im_rvalid = 1'b1;
        tick();
        im_rvalid = 1'b0;
        check("lat_d_pc_2",   d_pc,    32'h0000_3004);
        check("lat_valid_2",  {31'b0, d_valid}, 32'h1);
        check("lat_f_pc_2",   f_pc,    32'h0000_3008);

        // Stall coincident with the 0x3004 response, held three cycles.
        do_reset();
        im_rvalid = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        check("st_d_pc_h1",  d_pc,    32'h0000_3000);
        check("st_valid_h1", {31'b0, d_valid}, 32'h1);
        check("st_f_pc_h1",  f_pc,    32'h0000_3004);
        check("st_req_h1",   {31'b0, im_req},  32'h0);
        corrupt = 32'hFFFF_0000;
        tick();
        check("st_req_h2",   {31'b0, im_req},  32'h0);
        check("st_d_pc_h2",  d_pc,    32'h0000_3000);
        tick();
        check("st_req_h3",   {31'b0, im_req},  32'h0);
        stall     = 1'b0;
        im_rvalid = 1'b0;
        corrupt   = 32'h0;
        tick();
        check("st_d_pc_rel",  d_pc,    32'h0000_3004);
        check("st_instr_rel", d_instr, 32'hA000_3004);
        check("st_valid_rel", {31'b0, d_valid}, 32'h1);
        check("st_f_pc_rel",  f_pc,    32'h0000_3008);
        check("st_req_rel",   {31'b0, im_req},  32'h1);

        // Branch at 0x3000 in D targets 0x3100; slot at 0x3004 takes 3 cycles.
        do_reset();
        im_rvalid = 1'b1;
        tick();
        npc_seq   = 1'b0;
        npc_val   = 32'h0000_3100;
        im_rvalid = 1'b0;
        tick();
        check("br_valid_w1", {31'b0, d_valid}, 32'h0);
        check("br_f_pc_w1",  f_pc,    32'h0000_3004);
        npc_val = 32'h0000_3008;
        tick();
        tick();
        check("br_addr_w3",  im_addr, 32'h0000_3004);
        im_rvalid = 1'b1;
        tick();
        check("br_d_pc_slot",  d_pc,    32'h0000_3004);
        check("br_instr_slot", d_instr, 32'hA000_3004);
        check("br_f_pc_tgt",   f_pc,    32'h0000_3100);
        npc_seq = 1'b1;
        tick();
        check("br_d_pc_tgt",   d_pc,    32'h0000_3100);
        check("br_f_pc_next",  f_pc,    32'h0000_3104);

        // Reset asserted while waiting on a slow fetch.
        do_reset();
        im_rvalid = 1'b1;
        tick();
        im_rvalid = 1'b0;
        tick();
        check("rw_pre_req", {31'b0, im_req}, 32'h0);
        reset = 1'b1;
        #1;
        check("rw_f_pc",    f_pc,    32'h0000_3000);
        check("rw_d_pc",    d_pc,    32'h0);
        check("rw_d_instr", d_instr, 32'h0);
        check("rw_d_valid", {31'b0, d_valid}, 32'h0);
        check("rw_im_req",  {31'b0, im_req},  32'h1);
        tick();
        reset     = 1'b0;
        im_rvalid = 1'b1;
        tick();
        check("rw_restart_pc", d_pc, 32'h0000_3000);
        check("rw_restart_v",  {31'b0, d_valid}, 32'h1);

        // Misaligned next PC.
        do_reset();
        npc_seq   = 1'b0;
        npc_val   = 32'h0000_3006;
        im_rvalid = 1'b1;
        tick();
        check("al_f_pc",    f_pc,    32'h0000_3006);
        check("al_d_instr0", d_instr, 32'hA000_3000);
`ifdef FETCH_ALIGN_CHECK_EN
        check("al_adel",    {31'b0, exc_adel}, 32'h1);
        tick();
        check("al_d_instr1", d_instr, 32'h0);
        check("al_d_valid1", {31'b0, d_valid}, 32'h1);
        check("al_adel_hold", {31'b0, exc_adel}, 32'h1);
`else
        check("al_adel",    {31'b0, exc_adel}, 32'h0);
        tick();
        check("al_d_instr1", d_instr, 32'hA000_3006);
        check("al_d_valid1", {31'b0, d_valid}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
